// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the system-bus arbiter and its neighbours (address
// decoder, slave mux): arbiter state encoding, default bus widths and the
// width helpers used to size grant/index fields.
// ---------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_MASTERS = 4;
    localparam int DEF_SLAVE_SEL_W = 2;

    // Width of the 1-based owner number (0 reserved for "no owner").
    function automatic int gnt_width(input int num_masters);
        return $clog2(num_masters + 1);
    endfunction

    // Width of a 0-based master index; never narrower than one bit.
    function automatic int idx_width(input int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Combinational winner selection for the bus arbiter.
//   req     in   NUM_MASTERS  request vector, bit i = master i
//   rr_ptr  in   IDX_W        round-robin start index
//   mode    in   1            1 = search starts at rr_ptr, 0 = search starts at 0
//   winner  out  IDX_W        index of the selected master
//   valid   out  1            at least one request present
// ---------------------------------------------------------------------------
module rr_priority_picker
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int IDX_W       = idx_width(DEF_NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    input  logic                   mode,
    output logic [IDX_W-1:0]       winner,
    output logic                   valid
);

    logic [IDX_W-1:0] start;
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan NUM_MASTERS positions starting at 'start'; the extra bit in 'cand'
    // holds start+i before it is folded back into range.
    always_comb begin
        winner   = '0;
        valid    = 1'b0;
        cand     = '0;
        cand_idx = '0;
        start    = mode ? rr_ptr : '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = {1'b0, start} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_MASTERS)) begin
                cand = cand - (IDX_W+1)'(NUM_MASTERS);
            end
            cand_idx = cand[IDX_W-1:0];
            if (!valid && req[cand_idx]) begin
                valid  = 1'b1;
                winner = cand_idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
// N-master system-bus arbiter with fixed or round-robin priority. The owner
// and its slave select are locked for the whole transaction; an optional
// watchdog forces release if the slave never signals completion.
//   clk           in   1                        system clock
//   rst           in   1                        async reset, active-high
//   m_request     in   NUM_MASTERS              request per master
//   m_slave_sel   in   NUM_MASTERS*SLAVE_SEL_W  slave select per master
//   trans_done    in   1                        transaction complete pulse
//   m_grant       out  NUM_MASTERS              one-hot grant
//   arbiter_busy  out  1                        bus owned
//   bus_grant     out  GNT_W                    owner number (1-based), 0 = none
//   slave_sel     out  SLAVE_SEL_W              owner's slave select, latched at grant
//   timeout       out  1                        watchdog forced-release pulse
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no owner; requests evaluated every cycle
// ST_GRANT   | owner holds the bus until trans_done or watchdog expiry
// ST_RELEASE | one turnaround cycle with all grant outputs low
// ---------------------------------------------------------------------------
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
    parameter int SLAVE_SEL_W    = DEF_SLAVE_SEL_W,
    parameter int RR_MODE        = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_MASTERS-1:0]             m_request,
    input  logic [NUM_MASTERS*SLAVE_SEL_W-1:0] m_slave_sel,
    input  logic                               trans_done,
    output logic [NUM_MASTERS-1:0]             m_grant,
    output logic                               arbiter_busy,
    output logic [gnt_width(NUM_MASTERS)-1:0]  bus_grant,
    output logic [SLAVE_SEL_W-1:0]             slave_sel,
    output logic                               timeout
);

    localparam int   GNT_W   = gnt_width(NUM_MASTERS);
    localparam int   IDX_W   = idx_width(NUM_MASTERS);
    localparam logic MODE_RR = (RR_MODE != 0);

    arb_state_e state_q, state_d;

    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic [IDX_W-1:0]       ptr_next;
    logic [SLAVE_SEL_W-1:0] sel_pick;
    logic                   grant_now;
    logic                   wd_expire;

    logic [NUM_MASTERS-1:0] m_grant_d;
    logic                   busy_d;
    logic [GNT_W-1:0]       bus_grant_d;
    logic [SLAVE_SEL_W-1:0] slave_sel_d;
    logic                   timeout_d;

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req    (m_request),
        .rr_ptr (rr_ptr),
        .mode   (MODE_RR),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    assign grant_now = (state_q == ST_IDLE) && pick_valid;

    // Constant-index mux avoids a variable multiply in the part-select.
    always_comb begin
        sel_pick = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_pick = m_slave_sel[i*SLAVE_SEL_W +: SLAVE_SEL_W];
            end
        end
    end

    assign ptr_next = (pick_idx == IDX_W'(NUM_MASTERS-1)) ? '0 : pick_idx + IDX_W'(1);

    // Watchdog counts completed GRANT cycles; expiry is flagged during the
    // TIMEOUT_CYCLES-th grant cycle so the bus is held exactly that long.
    if (TIMEOUT_CYCLES > 0) begin : g_wd
        localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
        logic [WD_W-1:0] wd_cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wd_cnt <= '0;
            end else if (grant_now) begin
                wd_cnt <= '0;
            end else if (state_q == ST_GRANT) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end

        assign wd_expire = (state_q == ST_GRANT) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wd
        assign wd_expire = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next registered outputs. Outputs default to the
    // "no owner" values and are only held while the owner keeps the bus.
    always_comb begin
        state_d     = state_q;
        m_grant_d   = '0;
        busy_d      = 1'b0;
        bus_grant_d = '0;
        slave_sel_d = '0;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d             = ST_GRANT;
                    m_grant_d[pick_idx] = 1'b1;
                    busy_d              = 1'b1;
                    bus_grant_d         = GNT_W'(pick_idx) + GNT_W'(1);
                    slave_sel_d         = sel_pick;
                end
            end
            ST_GRANT: begin
                if (trans_done) begin
                    state_d = ST_RELEASE;
                end else if (wd_expire) begin
                    state_d   = ST_RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    m_grant_d   = m_grant;
                    busy_d      = arbiter_busy;
                    bus_grant_d = bus_grant;
                    slave_sel_d = slave_sel;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_grant      <= '0;
            arbiter_busy <= 1'b0;
            bus_grant    <= '0;
            slave_sel    <= '0;
            timeout      <= 1'b0;
        end else begin
            m_grant      <= m_grant_d;
            arbiter_busy <= busy_d;
            bus_grant    <= bus_grant_d;
            slave_sel    <= slave_sel_d;
            timeout      <= timeout_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_now) begin
            rr_ptr <= ptr_next;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] m_request = '0;
    logic [7:0] m_slave_sel = '0;
    logic       trans_done = 1'b0;

    logic [3:0] g_rr, g_fx;
    logic       busy_rr, busy_fx;
    logic [2:0] bg_rr, bg_fx;
    logic [1:0] ss_rr, ss_fx;
    logic       to_rr, to_fx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance 0: round-robin with an 8-cycle watchdog. Instance 1: fixed priority, no watchdog.
    bus_arbiter_rr #(.NUM_MASTERS(4), .SLAVE_SEL_W(2), .RR_MODE(1), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .m_request(m_request), .m_slave_sel(m_slave_sel),
        .trans_done(trans_done), .m_grant(g_rr), .arbiter_busy(busy_rr),
        .bus_grant(bg_rr), .slave_sel(ss_rr), .timeout(to_rr)
    );

    bus_arbiter_rr #(.NUM_MASTERS(4), .SLAVE_SEL_W(2), .RR_MODE(0), .TIMEOUT_CYCLES(0)) dut_fx (
        .clk(clk), .rst(rst), .m_request(m_request), .m_slave_sel(m_slave_sel),
        .trans_done(trans_done), .m_grant(g_fx), .arbiter_busy(busy_fx),
        .bus_grant(bg_fx), .slave_sel(ss_fx), .timeout(to_fx)
    );

    logic [3:0] o_g  [2];
    logic       o_b  [2];
    logic [2:0] o_bg [2];
    logic [1:0] o_ss [2];
    logic       o_to [2];
    assign o_g[0] = g_rr;    assign o_g[1] = g_fx;
    assign o_b[0] = busy_rr; assign o_b[1] = busy_fx;
    assign o_bg[0] = bg_rr;  assign o_bg[1] = bg_fx;
    assign o_ss[0] = ss_rr;  assign o_ss[1] = ss_fx;
    assign o_to[0] = to_rr;  assign o_to[1] = to_fx;

    // Reference model: owner number (-1 = none), cycles left before requests
    // are looked at again, cycles the owner has held the bus, rr pointer.
    int mode_k [2] = '{1, 0};
    int tmo_k  [2] = '{8, 0};
    int own [2];
    int gap [2];
    int age [2];
    int ptr [2];
    int sel [2];
    int tov [2];

    function automatic int pick(input int k, input logic [3:0] req);
        int base;
        int c;
        base = (mode_k[k] != 0) ? ptr[k] : 0;
        for (int j = 0; j < 4; j++) begin
            c = (base + j) % 4;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k] = -1; gap[k] = 0; age[k] = 0; ptr[k] = 0; sel[k] = 0; tov[k] = 0;
        end
    endtask

    task automatic model_step();
        int w;
        for (int k = 0; k < 2; k++) begin
            tov[k] = 0;
            if (own[k] >= 0) begin
                age[k] = age[k] + 1;
                if (trans_done) begin
                    own[k] = -1; gap[k] = 1;
                end else if (tmo_k[k] > 0 && age[k] == tmo_k[k]) begin
                    own[k] = -1; gap[k] = 1; tov[k] = 1;
                end
            end else if (gap[k] > 0) begin
                gap[k] = gap[k] - 1;
            end else begin
                w = pick(k, m_request);
                if (w >= 0) begin
                    own[k] = w;
                    age[k] = 0;
                    sel[k] = int'((m_slave_sel >> (2 * w)) & 8'h3);
                    ptr[k] = (w + 1) % 4;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("m_grant[%0d]", k), 32'(o_g[k]), (own[k] >= 0) ? (32'd1 << own[k]) : 32'd0);
            check($sformatf("busy[%0d]", k), 32'(o_b[k]), (own[k] >= 0) ? 32'd1 : 32'd0);
            check($sformatf("bus_grant[%0d]", k), 32'(o_bg[k]), 32'(own[k] + 1));
            check($sformatf("slave_sel[%0d]", k), 32'(o_ss[k]), (own[k] >= 0) ? 32'(sel[k]) : 32'd0);
            check($sformatf("timeout[%0d]", k), 32'(o_to[k]), 32'(tov[k]));
            check($sformatf("onehot0[%0d]", k), 32'($onehot0(o_g[k])), 32'd1);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic pulse_done();
        trans_done = 1'b1;
        cycle();
        trans_done = 1'b0;
    endtask

    // Advance until the round-robin instance owns the bus; n = edges taken.
    task automatic wait_busy(input string tag, output int n);
        n = 0;
        while (!busy_rr && n < 8) begin
            cycle();
            n++;
        end
        check({tag, "_reached_grant"}, 32'(busy_rr), 32'd1);
    endtask

    int n;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        model_reset();

        // Reset state
        cycle();
        cycle();
        check("reset_grant", 32'(g_rr), 32'd0);
        check("reset_bus_grant", 32'(bg_rr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // trans_done in IDLE without requests changes nothing
        trans_done = 1'b1;
        cycle();
        cycle();
        trans_done = 1'b0;
        cycle();
        check("idle_done_busy", 32'(busy_rr), 32'd0);
        check("idle_done_timeout", 32'(to_rr), 32'd0);

        // Round-robin order with all masters requesting, 2-cycle turnaround
        m_request   = 4'b1111;
        m_slave_sel = 8'b11_10_01_00;
        for (int g = 0; g < 5; g++) begin
            wait_busy($sformatf("rr%0d", g), n);
            if (g > 0) check($sformatf("rr_gap%0d", g), 32'(n), 32'd2);
            check($sformatf("rr_order%0d", g), 32'(g_rr), 32'd1 << exp_order[g]);
            check($sformatf("rr_bus_grant%0d", g), 32'(bg_rr), 32'(exp_order[g] + 1));
            check($sformatf("rr_slave_sel%0d", g), 32'(ss_rr), 32'(exp_order[g]));
            check($sformatf("fx_always0_%0d", g), 32'(g_fx), 32'd1);
            pulse_done();
        end

        // Fixed priority, req 0110 -> master 1
        m_request   = 4'b0110;
        m_slave_sel = 8'b10_01_11_00;
        wait_busy("fixed", n);
        check("fixed_grant", 32'(g_fx), 32'b0010);
        check("fixed_bus_grant", 32'(bg_fx), 32'd2);
        check("fixed_slave_sel", 32'(ss_fx), 32'd3);

        // No preemption, slave_sel locked while master 2 owns the bus
        m_request = 4'b0101;
        pulse_done();
        wait_busy("lock", n);
        check("lock_owner", 32'(g_rr), 32'b0100);
        m_request   = 4'b0001;
        m_slave_sel = 8'b10_10_11_00;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("lock_grant%0d", i), 32'(g_rr), 32'b0100);
            check($sformatf("lock_sel%0d", i), 32'(ss_rr), 32'd1);
            check($sformatf("lock_bus_grant%0d", i), 32'(bg_rr), 32'd3);
        end

        // Watchdog: 8 grant cycles, then timeout pulse and re-arbitration
        m_request = 4'b1000;
        pulse_done();
        wait_busy("wd", n);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (!busy_rr) break;
            n++;
        end
        check("wd_grant_cycles", 32'(n), 32'd8);
        check("wd_timeout_pulse", 32'(to_rr), 32'd1);
        cycle();
        check("wd_timeout_single", 32'(to_rr), 32'd0);
        cycle();
        check("wd_regrant", 32'(g_rr), 32'b1000);

        // Async reset mid-grant after rr_ptr has moved away from 0
        m_request = 4'b0010;
        pulse_done();
        wait_busy("pre_rst", n);
        check("pre_rst_owner", 32'(g_rr), 32'b0010);
        cycle();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("async_rst_grant", 32'(g_rr), 32'd0);
        check("async_rst_busy", 32'(busy_rr), 32'd0);
        m_request = 4'b1111;
        cycle();
        @(negedge clk);
        rst = 1'b0;
        wait_busy("post_rst", n);
        check("post_rst_first", 32'(g_rr), 32'b0001);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) m_request = 4'($urandom_range(0, 15));
            m_slave_sel = 8'($urandom);
            trans_done  = ($urandom_range(0, 3) == 0);
            cycle();
        end
        trans_done = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
